mmcm_drp_ctrl: RTL and testbench
================================

MMCM_DRP_CTRL -- requirements
Module: mmcm_drp_ctrl

Interface
REQ-001 Parameters SHALL be: TIMEOUT_CYCLES, default 1024, max cycles waited for drp_drdy or lock; LOCK_SETTLE, default 16, consecutive synced-lock cycles required.
REQ-002 Clock and reset SHALL be one clock and a synchronous, active-high reset.
REQ-003 sys_clk  in  1  sole clock; all logic rising-edge.
REQ-004 sys_rst  in  1  synchronous, active-high reset.
REQ-005 req  in  1  single-cycle request strobe.
REQ-006 req_addr  in  7  DRP register address.
REQ-007 req_data  in  16  new field value.
REQ-008 req_mask  in  16  1 = preserve the existing bit, 0 = take the req_data bit.
REQ-009 busy  out  1  operation in progress.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 err  out  1  sticky timeout flag.
REQ-012 drp_den, drp_dwe  out  1 each  DRP enable and write enable.
REQ-013 drp_daddr  out  7;  drp_di  out  16;  drp_do  in  16;  drp_drdy  in  1  MMCM DRP port.
REQ-014 mmcm_locked  in  1  asynchronous MMCM LOCKED.
REQ-015 mmcm_rst  out  1  MMCM RST, held high during reprogramming.

Function
REQ-016 States SHALL be IDLE, RST, RD, WAIT_RD, WR, WAIT_WR, RELEASE, WAIT_LOCK and DONE.
REQ-017 In IDLE with req=1 and busy=0, the block SHALL capture addr/data/mask, and the next cycle SHALL have busy=1, mmcm_rst=1 and state RST; req while busy=1 SHALL be ignored.
REQ-018 RST SHALL last exactly 1 cycle, then go to RD.
REQ-019 RD: drp_den=1 and drp_dwe=0 for exactly one cycle with drp_daddr=captured addr, then go to WAIT_RD.
REQ-020 WAIT_RD: on drp_drdy=1 the block SHALL register drp_di = (drp_do & mask) | (req_data & ~mask) and go to WR.
REQ-021 WR: drp_den=1 and drp_dwe=1 for exactly one cycle, then go to WAIT_WR.
REQ-022 WAIT_WR: on drp_drdy=1 go to RELEASE.
REQ-023 RELEASE: mmcm_rst=0 for 1 cycle, then go to WAIT_LOCK.
REQ-024 mmcm_locked SHALL pass through a 2-flop synchronizer before any use.
REQ-025 WAIT_LOCK: a settle counter SHALL increment while synced lock=1 and clear to 0 when lock=0; reaching LOCK_SETTLE SHALL go to DONE.
REQ-026 DONE: done=1 and busy=0 in the same cycle, then go to IDLE; a new req SHALL be accepted from the following cycle.
REQ-027 drp_drdy outside WAIT_RD/WAIT_WR SHALL be ignored.
REQ-028 drp_den SHALL never be high on two consecutive cycles.
REQ-029 err SHALL clear on acceptance of the next request.

Reset
REQ-030 sys_rst SHALL force state to IDLE within one cycle, including mid-operation, and release mmcm_rst.
REQ-031 Reset values SHALL be: mmcm_rst=0, drp_den=0, drp_dwe=0, drp_daddr=0, drp_di=0, busy=0, done=0, err=0, all counters 0.

Configuration
REQ-032 Macro MMCM_DRP_TIMEOUT_EN SHALL enable the timeout function.
REQ-033 With MMCM_DRP_TIMEOUT_EN defined, a wait counter SHALL clear on entry to WAIT_RD, WAIT_WR and WAIT_LOCK.
REQ-034 With MMCM_DRP_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES in any of those states SHALL set err=1, force mmcm_rst=0, skip the remaining DRP accesses and go to DONE.
REQ-035 With MMCM_DRP_TIMEOUT_EN undefined, the block SHALL wait indefinitely and err SHALL be constant 0.

Verification
REQ-036 Nominal: req addr=0x08, data=0x1234, mask=0xF000; DRP model returns 0xABCD after 3 cycles -> write drp_di=0xA234; mmcm_rst high from cycle 1 until RELEASE; done after LOCK_SETTLE lock cycles; err=0.
REQ-037 Lock glitch: lock high 10 cycles, low 1 cycle, then high -> settle counter restarts; done occurs 16 cycles after re-lock.
REQ-038 Busy collision: second req with addr=0x09 issued mid-operation -> ignored; exactly one read and one write, both to 0x08.
REQ-039 Timeout (macro defined, TIMEOUT_CYCLES=1024): drp_drdy never returns -> err=1 and done pulse 1024 cycles after RD; mmcm_rst=0; no write issued.
REQ-040 Mid-operation reset: sys_rst asserted in WAIT_WR -> next cycle busy=0, mmcm_rst=0, drp_den=0; a subsequent req completes normally.

Source files
------------

// File: rtl/mmcm_drp_ctrl_if.sv
// Host-side request/status handshake for mmcm_drp_ctrl.
interface mmcm_drp_ctrl_if;
    logic        req;
    logic [6:0]  req_addr;
    logic [15:0] req_data;
    logic [15:0] req_mask;
    logic        busy;
    logic        done;
    logic        err;

    modport master (output req, req_addr, req_data, req_mask, input busy, done, err);
    modport slave  (input req, req_addr, req_data, req_mask, output busy, done, err);
endinterface

// File: rtl/mmcm_drp_ctrl.sv
// MMCM DRP read-modify-write sequencer: holds the MMCM in reset, patches one register, waits for lock.
// Define MMCM_DRP_TIMEOUT_EN to enable the drdy/lock wait timeout and the sticky err flag.
module mmcm_drp_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned LOCK_SETTLE    = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    mmcm_drp_ctrl_if.slave   host,
    output logic             drp_den,
    output logic             drp_dwe,
    output logic [6:0]       drp_daddr,
    output logic [15:0]      drp_di,
    input  logic [15:0]      drp_do,
    input  logic             drp_drdy,
    input  logic             mmcm_locked,
    output logic             mmcm_rst
);
`ifdef MMCM_DRP_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam int unsigned SW = $clog2(LOCK_SETTLE + 1);
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_SETTLE - 1);
    localparam logic [WW-1:0] WAIT_LAST   = WW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, RST, RD, WAIT_RD, WR, WAIT_WR, RELEASE, WAIT_LOCK, DONE
    } state_t;

    state_t        state, next;
    logic [15:0]   data_q, mask_q;
    logic          lock_meta, lock_sync;
    logic [SW-1:0] settle_cnt;
    logic [WW-1:0] wait_cnt;
    logic          in_wait, timeout, expire, err_q;

    assign in_wait = state inside {WAIT_RD, WAIT_WR, WAIT_LOCK};
    // With the timeout disabled this is constant 0, so wait_cnt and err_q fold away.
    assign timeout = TIMEOUT_EN && in_wait && (wait_cnt == WAIT_LAST);

    always_comb begin
        next   = state;
        expire = 1'b0;
        unique case (state)
            IDLE:      if (host.req) next = RST;
            RST:       next = RD;
            RD:        next = WAIT_RD;
            WAIT_RD: begin
                if (drp_drdy)     next = WR;
                else if (timeout) begin next = DONE; expire = 1'b1; end
            end
            WR:        next = WAIT_WR;
            WAIT_WR: begin
                if (drp_drdy)     next = RELEASE;
                else if (timeout) begin next = DONE; expire = 1'b1; end
            end
            RELEASE:   next = WAIT_LOCK;
            WAIT_LOCK: begin
                if (lock_sync && settle_cnt == SETTLE_LAST) next = DONE;
                else if (timeout) begin next = DONE; expire = 1'b1; end
            end
            DONE:      next = IDLE;
            default:   next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= IDLE;
            drp_daddr  <= '0;
            drp_di     <= '0;
            data_q     <= '0;
            mask_q     <= '0;
            lock_meta  <= 1'b0;
            lock_sync  <= 1'b0;
            settle_cnt <= '0;
            wait_cnt   <= '0;
            err_q      <= 1'b0;
        end else begin
            state     <= next;
            lock_meta <= mmcm_locked;
            lock_sync <= lock_meta;
            if (state == IDLE && host.req) begin
                drp_daddr <= host.req_addr;
                data_q    <= host.req_data;
                mask_q    <= host.req_mask;
                err_q     <= 1'b0;
            end
            // Mask bit 1 keeps the value read back from the MMCM.
            if (state == WAIT_RD && drp_drdy)
                drp_di <= (drp_do & mask_q) | (data_q & ~mask_q);
            settle_cnt <= (state == WAIT_LOCK && lock_sync) ? settle_cnt + SW'(1) : '0;
            wait_cnt   <= in_wait ? wait_cnt + WW'(1) : '0;
            if (expire) err_q <= 1'b1;
        end
    end

    assign host.busy = !(state == IDLE || state == DONE);
    assign host.done = (state == DONE);
    assign host.err  = TIMEOUT_EN ? err_q : 1'b0;
    assign mmcm_rst  = state inside {RST, RD, WAIT_RD, WR, WAIT_WR};
    assign drp_den   = (state == RD) || (state == WR);
    assign drp_dwe   = (state == WR);
endmodule

// File: tb/tb_mmcm_drp_ctrl.sv
// Randomized self-checking bench for mmcm_drp_ctrl with a DRP register-file model and an MMCM lock model.
module tb_mmcm_drp_ctrl;
    localparam int unsigned TO     = 1024;
    localparam int unsigned LS     = 16;
    localparam int unsigned BUDGET = 3000;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        drp_den, drp_dwe, drp_drdy;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_di, drp_do;
    logic        mmcm_locked, mmcm_rst;

    mmcm_drp_ctrl_if host ();

    mmcm_drp_ctrl #(.TIMEOUT_CYCLES(TO), .LOCK_SETTLE(LS)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .host        (host),
        .drp_den     (drp_den),
        .drp_dwe     (drp_dwe),
        .drp_daddr   (drp_daddr),
        .drp_di      (drp_di),
        .drp_do      (drp_do),
        .drp_drdy    (drp_drdy),
        .mmcm_locked (mmcm_locked),
        .mmcm_rst    (mmcm_rst)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // DRP register file: answers each access drp_lat cycles later (0 = never answers).
    logic [15:0] mem [128];
    int          drp_lat = 3;
    bit          spurious_en = 1'b0;
    bit          acc_we [$];
    logic [6:0]  acc_a  [$];
    logic [15:0] acc_d  [$];
    bit          pend = 1'b0;
    bit          pend_we;
    logic [6:0]  pend_a;
    logic [15:0] pend_d;
    int          pend_cnt;
    logic [15:0] last_wdata = '0;

    initial begin
        drp_drdy = 1'b0;
        drp_do   = '0;
        forever begin
            @(negedge sys_clk);
            drp_drdy = 1'b0;
            if (pend) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    drp_drdy = 1'b1;
                    pend     = 1'b0;
                    if (pend_we) begin
                        mem[pend_a] = pend_d;
                        drp_do = 16'($urandom);
                    end else begin
                        drp_do = mem[pend_a];
                    end
                end
            end else if (spurious_en && $urandom_range(0, 3) == 0) begin
                drp_drdy = 1'b1;
                drp_do   = 16'($urandom);
            end
            if (drp_den) begin
                acc_we.push_back(drp_dwe);
                acc_a.push_back(drp_daddr);
                acc_d.push_back(drp_di);
                if (drp_lat > 0) begin
                    pend = 1'b1; pend_cnt = drp_lat;
                    pend_we = drp_dwe; pend_a = drp_daddr; pend_d = drp_di;
                end
            end
        end
    end

    int den_bad  = 0;
    bit prev_den = 1'b0;
    initial begin
        forever begin
            @(negedge sys_clk);
            if (drp_den && prev_den) den_bad++;
            prev_den = drp_den;
        end
    end

    task automatic clear_log();
        acc_we.delete(); acc_a.delete(); acc_d.delete();
    endtask

    // One full request; lock rises a random delay after release, optionally with a one-cycle dropout.
    task automatic run_op(input logic [6:0] a, input logic [15:0] d, input logic [15:0] m,
                          input bit glitch, input bit collide);
        logic [15:0] exp_w;
        int cyc, rise, last_rise, done_cyc, busy_bad, rst_bad;
        bit released, done_seen;
        exp_w = (mem[a] & m) | (d & ~m);
        spurious_en = 1'b0;
        @(negedge sys_clk);
        check("idle_done", host.done, 0);
        check("idle_busy", host.busy, 0);
        clear_log();
        host.req = 1'b1; host.req_addr = a; host.req_data = d; host.req_mask = m;
        @(negedge sys_clk);
        host.req = 1'b0;
        mmcm_locked = 1'b0;
        check("accept_busy", host.busy, 1);
        check("accept_mmcm_rst", mmcm_rst, 1);
        check("accept_err_clear", host.err, 0);
        cyc = 1; released = 0; done_seen = 0; rise = 0; last_rise = 0;
        done_cyc = 0; busy_bad = 0; rst_bad = 0;
        while (cyc < BUDGET) begin
            if (host.done) begin done_seen = 1; done_cyc = cyc; break; end
            if (!host.busy) busy_bad++;
            if (!released) begin
                if (!mmcm_rst) begin
                    released    = 1;
                    rise        = cyc + $urandom_range(0, 3);
                    last_rise   = glitch ? rise + 11 : rise;
                    spurious_en = 1'b1;
                    check("write_before_release", acc_we.size(), 2);
                end
            end else if (mmcm_rst) rst_bad++;
            if (released)
                mmcm_locked = glitch ? ((cyc >= rise && cyc < rise + 10) || cyc >= rise + 11)
                                     : (cyc >= rise);
            host.req = collide && cyc == 4;
            if (collide && cyc == 4) begin
                host.req_addr = 7'h09; host.req_data = 16'($urandom);
            end
            @(negedge sys_clk);
            cyc++;
        end
        host.req = 1'b0;
        check("done_seen", done_seen, 1);
        check("done_cycle", done_cyc, last_rise + 2 + LS);
        check("done_busy", host.busy, 0);
        check("done_err", host.err, 0);
        check("done_mmcm_rst", mmcm_rst, 0);
        check("busy_hold", busy_bad, 0);
        check("rst_window", rst_bad, 0);
        check("access_count", acc_we.size(), 2);
        if (acc_we.size() == 2) begin
            check("rd_kind", acc_we[0], 0);
            check("rd_addr", acc_a[0], a);
            check("wr_kind", acc_we[1], 1);
            check("wr_addr", acc_a[1], a);
            check("wr_data", acc_d[1], exp_w);
            last_wdata = acc_d[1];
        end
    endtask

    task automatic reset_mid_op();
        int n;
        spurious_en = 1'b0;
        drp_lat = 4;
        @(negedge sys_clk);
        host.req = 1'b1; host.req_addr = 7'($urandom);
        host.req_data = 16'($urandom); host.req_mask = 16'($urandom);
        @(negedge sys_clk);
        host.req = 1'b0;
        mmcm_locked = 1'b0;
        n = 0;
        while (!drp_dwe && n < 50) begin @(negedge sys_clk); n++; end
        check("reach_wr", drp_dwe, 1);
        @(negedge sys_clk);
        check("wait_wr_busy", host.busy, 1);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        check("mid_rst_busy", host.busy, 0);
        check("mid_rst_mmcm_rst", mmcm_rst, 0);
        check("mid_rst_den", drp_den, 0);
        check("mid_rst_done", host.done, 0);
        repeat (8) @(negedge sys_clk);
    endtask

`ifdef MMCM_DRP_TIMEOUT_EN
    task automatic timeout_op();
        int cyc, rd;
        bit seen;
        spurious_en = 1'b0;
        drp_lat = 0;
        @(negedge sys_clk);
        clear_log();
        host.req = 1'b1; host.req_addr = 7'h08;
        host.req_data = 16'($urandom); host.req_mask = 16'($urandom);
        @(negedge sys_clk);
        host.req = 1'b0;
        mmcm_locked = 1'b0;
        cyc = 1; rd = 0;
        while (!drp_den && cyc < 50) begin @(negedge sys_clk); cyc++; end
        rd = cyc;
        seen = 0;
        while (cyc < rd + TO + 50) begin
            if (host.done) begin seen = 1; break; end
            @(negedge sys_clk); cyc++;
        end
        check("to_done_seen", seen, 1);
        check("to_done_cycle", cyc, rd + 1 + TO);
        check("to_err", host.err, 1);
        check("to_mmcm_rst", mmcm_rst, 0);
        check("to_no_write", acc_we.size(), 1);
        @(negedge sys_clk);
        check("to_err_sticky", host.err, 1);
        check("to_done_pulse", host.done, 0);
        mmcm_locked = 1'b1;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [15:0] m;
        host.req = 1'b0; host.req_addr = '0; host.req_data = '0; host.req_mask = '0;
        sys_rst = 1'b1;
        mmcm_locked = 1'b1;
        for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
        repeat (3) @(negedge sys_clk);
        check("rst_busy", host.busy, 0);
        check("rst_done", host.done, 0);
        check("rst_err", host.err, 0);
        check("rst_den", drp_den, 0);
        check("rst_dwe", drp_dwe, 0);
        check("rst_daddr", drp_daddr, 0);
        check("rst_di", drp_di, 0);
        check("rst_mmcm_rst", mmcm_rst, 0);
        sys_rst = 1'b0;

        mem[8] = 16'hABCD;
        drp_lat = 3;
        run_op(7'h08, 16'h1234, 16'hF000, 1'b0, 1'b0);
        check("nominal_wdata", last_wdata, 16'hA234);

        drp_lat = 2;
        run_op(7'h08, 16'($urandom), 16'($urandom), 1'b1, 1'b0);
        run_op(7'h08, 16'($urandom), 16'($urandom), 1'b0, 1'b1);

        for (int i = 0; i < 12; i++) begin
            drp_lat = $urandom_range(1, 4);
            case ($urandom_range(0, 2))
                0:       m = 16'h0000;
                1:       m = 16'hFFFF;
                default: m = 16'($urandom);
            endcase
            run_op(7'($urandom), 16'($urandom), m, $urandom_range(0, 3) == 0, 1'b0);
        end

        reset_mid_op();
        drp_lat = $urandom_range(1, 4);
        run_op(7'($urandom), 16'($urandom), 16'($urandom), 1'b0, 1'b0);

`ifdef MMCM_DRP_TIMEOUT_EN
        timeout_op();
        drp_lat = 3;
        run_op(7'h08, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
`endif

        check("den_spacing", den_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
